// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one SLICE-bit carry-lookahead adder,
// stepping LSB slice to MSB slice with the slice carry held in a register between steps.

module cla_grp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       gg,
    output logic       gp
);
    logic [3:0] p, g, c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        s    = p ^ c;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp   = &p;
    end
endmodule

module cla_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_top
);
    localparam int NGRP = SLICE / 4;

    logic [NGRP-1:0] gg, gp;
    logic [NGRP:0]   gc;

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        cla_grp4 u_grp (
            .a (a[4*j +: 4]),
            .b (b[4*j +: 4]),
            .ci(gc[j]),
            .s (s[4*j +: 4]),
            .gg(gg[j]),
            .gp(gp[j])
        );
    end

    // Flat lookahead: each group carry is a sum of generate terms gated by the
    // propagates above them, so no carry ripples group-to-group.
    always_comb begin : la
        logic t;
        gc    = '0;
        gc[0] = ci;
        for (int j = 1; j <= NGRP; j++) begin
            t = ci;
            for (int m = 0; m < j; m++) t = t & gp[m];
            gc[j] = t;
            for (int k = 0; k < j; k++) begin
                t = gg[k];
                for (int m = k + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end
    end

    assign co    = gc[NGRP];
    assign c_top = s[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              c_q, cout_q, ovf_q;
    logic [IDXW-1:0]   idx_q;
    logic [SLICE-1:0]  s_s;
    logic              s_co, s_ctop, last;

    assign last = (idx_q == IDXW'(NSLICE - 1));

    cla_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_q[idx_q*SLICE +: SLICE]),
        .b    (b_q[idx_q*SLICE +: SLICE]),
        .ci   (c_q),
        .s    (s_s),
        .co   (s_co),
        .c_top(s_ctop)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted at capture and the +1 rides in the carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= sub ? ~b : b;
                    c_q   <= sub ? 1'b1 : cin;
                    idx_q <= '0;
                    sum_q <= '0;
                end
                RUN: begin
                    sum_q[idx_q*SLICE +: SLICE] <= s_s;
                    c_q <= s_co;
                    if (last) begin
                        cout_q <= s_co;
                        ovf_q  <= s_ctop ^ s_co;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized bench for cla_seq_adder: a 64/16 instance plus a 16/16 single-slice instance,
// both checked against a plain-arithmetic add/subtract reference.

module tb_cla_seq_adder;
    localparam int W = 64;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf, busy;
    logic [63:0] sum;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, cout1, ovf1, busy1;
    logic [15:0] sum1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(64), .SLICE(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .busy(busy)
    );

    cla_seq_adder #(.WIDTH(16), .SLICE(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    // Returns {ovf, cout, sum} of an exact w-bit add/subtract.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                            input logic ci, input logic s);
        logic [63:0] mask, yy, r;
        logic [64:0] full;
        logic        co, ov;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x    = x & mask;
        yy   = (s ? ~y : y) & mask;
        full = {1'b0, x} + {1'b0, yy} + {64'd0, (s ? 1'b1 : ci)};
        r    = full[63:0] & mask;
        co   = full[w];
        ov   = (x[w-1] == yy[w-1]) && (r[w-1] != x[w-1]);
        return {ov, co, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) rst = 1'b0;
            vectors++;
            if ({in_ready, out_valid, busy, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, want 1 0 0 0 0 0",
                         i, in_ready, out_valid, busy, sum, cout, ovf);
            end
            vectors++;
            if ({in_ready1, out_valid1, busy1, sum1} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
                miscompares++;
                $display("FAIL reset1[%0d]: rdy=%b vld=%b busy=%b sum=%h", i, in_ready1, out_valid1, busy1, sum1);
            end
        end
    endtask

    // One full operation on the 64-bit instance; out_ready held off for `stall` DONE cycles.
    task automatic do_op(input logic [63:0] ai, input logic [63:0] bi, input logic ci, input logic si,
                         input int stall, input string name);
        logic [65:0] exp;
        int lat;
        exp = ref_add(W, ai, bi, ci, si);
        a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
        out_ready = (stall == 0);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({busy, in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL %s busy/in_ready after accept: got %b%b want 10", name, busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom); sub = 1'($urandom);
            tick();
            lat++;
        end
        vectors++;
        if (lat != NS) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, NS);
        end
        vectors++;
        if ({ovf, cout, sum} !== exp) begin
            miscompares++;
            $display("FAIL %s result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     name, ovf, cout, sum, exp[65], exp[64], exp[63:0]);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            vectors++;
            if ({out_valid, in_ready, ovf, cout, sum} !== {2'b10, exp}) begin
                miscompares++;
                $display("FAIL %s stall[%0d]: vld=%b rdy=%b sum=%h want vld=1 rdy=0 sum=%h",
                         name, i, out_valid, in_ready, sum, exp[63:0]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, in_ready, ovf, cout, sum} !== {2'b01, exp}) begin
            miscompares++;
            $display("FAIL %s post-handshake: vld=%b rdy=%b sum=%h want vld=0 rdy=1 sum=%h",
                     name, out_valid, in_ready, sum, exp[63:0]);
        end
    endtask

    task automatic test_carry_ripple();
        do_op('1, 64'd0, 1'b1, 1'b0, 0, "carry_ripple");
        do_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, "carry_half");
    endtask

    task automatic test_subtract();
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0, "sub_ovf");
        do_op(64'd1, 64'd2, 1'b1, 1'b1, 1, "sub_borrow");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 2, "add_ovf");
    endtask

    task automatic test_back_to_back();
        logic [63:0] a0, b0, a2, b2;
        logic [65:0] e0, e2;
        int lat;
        a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        e0 = ref_add(W, a0, b0, 1'b1, 1'b0);
        e2 = ref_add(W, a2, b2, 1'b0, 1'b1);
        a = a0; b = b0; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        vectors++;
        if (lat != NS) begin
            miscompares++;
            $display("FAIL bp latency: got %0d want %0d", lat, NS);
        end
        for (int i = 0; i < 5; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom); sub = 1'($urandom);
            vectors++;
            if ({in_ready, out_valid, ovf, cout, sum} !== {2'b01, e0}) begin
                miscompares++;
                $display("FAIL bp hold[%0d]: rdy=%b vld=%b sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, in_ready, out_valid, sum, cout, ovf, e0[63:0], e0[64], e0[65]);
            end
            tick();
        end
        a = a2; b = b2; cin = 1'b0; sub = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({busy, in_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp next accept: busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        vectors++;
        if (lat != NS || {ovf, cout, sum} !== e2) begin
            miscompares++;
            $display("FAIL bp next result: lat=%0d sum=%h cout=%b ovf=%b want lat=%0d sum=%h cout=%b ovf=%b",
                     lat, sum, cout, ovf, NS, e2[63:0], e2[64], e2[65]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 64'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_mid: rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if ({out_valid, in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL reset_mid idle[%0d]: vld=%b rdy=%b want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++)
            do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3), "random");
    endtask

    // Single-slice instance: RUN lasts exactly one cycle.
    task automatic test_nslice1(input int n);
        logic [65:0] exp;
        logic [15:0] ai, bi;
        logic ci, si;
        int stall;
        for (int i = 0; i < n; i++) begin
            ai = 16'($urandom); bi = 16'($urandom); ci = 1'($urandom); si = 1'($urandom);
            if (i == 0) begin ai = 16'h8000; bi = 16'h0001; si = 1'b1; end
            exp = ref_add(16, {48'd0, ai}, {48'd0, bi}, ci, si);
            a1 = ai; b1 = bi; cin1 = ci; sub1 = si; in_valid1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            a1 = 16'($urandom); b1 = 16'($urandom);
            tick();
            vectors++;
            if ({out_valid1, ovf1, cout1, sum1} !== {1'b1, exp[65], exp[64], exp[15:0]}) begin
                miscompares++;
                $display("FAIL nslice1[%0d]: vld=%b sum=%h cout=%b ovf=%b want vld=1 sum=%h cout=%b ovf=%b",
                         i, out_valid1, sum1, cout1, ovf1, exp[15:0], exp[64], exp[65]);
            end
            stall = $urandom_range(0, 2);
            repeat (stall) tick();
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
            vectors++;
            if ({in_ready1, out_valid1} !== 2'b10) begin
                miscompares++;
                $display("FAIL nslice1 release[%0d]: rdy=%b vld=%b want 1 0", i, in_ready1, out_valid1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_subtract();
        test_back_to_back();
        test_reset_mid();
        test_random(2000);
        test_nslice1(2000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Output contract that holds every cycle.
    always @(negedge clk) begin
        if (!rst && in_ready && out_valid) begin
            miscompares++;
            $display("FAIL ready_valid_exclusive: in_ready=1 out_valid=1 at %0t", $time);
        end
    end
endmodule
